// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the cache-to-DMEM line interface.
package mem_if_pkg;
    localparam int LINE_W = 128;
    localparam int WORD_W = 32;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    // Full line number of a byte address; callers keep only the index bits they need.
    function automatic logic [31:0] line_idx(input logic [31:0] addr);
        return addr >> 4;
    endfunction
endpackage

// File: rtl/mem_line_responder_if.sv
// Line request/response bus between the cache controller (master) and main memory (slave).
interface mem_line_responder_if #(parameter int LINE_W = mem_if_pkg::LINE_W);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_we;
    logic [LINE_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_we, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_we, resp_rdata
    );
endinterface

// File: rtl/mem_line_responder.sv
// Fixed-latency main-memory line responder: one outstanding line read or write at a time.
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_line_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [LINE_W-1:0] memArray [DEPTH];

    resp_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              access;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [LINE_W-1:0] acc_wdata;
    logic [31:0]       req_line;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr_hi;

    assign req_line       = line_idx(bus.req_addr);
    assign req_idx        = req_line[IDX_W-1:0];
    assign unused_addr_hi = ^req_line[31:IDX_W];

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_we    = (state_q == RESP) && we_q;
    assign bus.resp_rdata = rdata_q;
    assign accept         = bus.req_valid && bus.req_ready;

    // An access from IDLE is only the single-cycle-latency path, so it must use the live request.
    assign acc_idx   = (state_q == IDLE) ? req_idx       : idx_q;
    assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = req_idx;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            rdata_d = acc_we ? '0 : memArray[acc_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Backing store survives reset; a write is committed only on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (!reset && access && acc_we) begin
            memArray[acc_idx] <= acc_wdata;
        end
    end
endmodule
